// File: rtl/data_bus_if_pkg.sv
// Shared definitions for the data-side Wishbone master bridge:
// FSM state encoding and the common bus constants.
package data_bus_if_pkg;

  localparam int unsigned RegBusWidth = 32;
  localparam int unsigned SelWidth    = 4;
  localparam int unsigned StallWidth  = 6;

  typedef logic [RegBusWidth-1:0] reg_bus_t;

  localparam reg_bus_t ZeroWord     = 32'h0000_0000;
  localparam logic     WriteEnable  = 1'b1;
  localparam logic     WriteDisable = 1'b0;
  localparam logic     ChipEnable   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE           = 2'd0,
    ST_BUSY           = 2'd1,
    ST_WAIT_FOR_STALL = 2'd2
  } bus_state_e;

endpackage

// File: rtl/data_bus_if.sv
// Wishbone classic master for the data side: turns the memory-access stage's
// combinational request into one registered single-transfer bus cycle.
module data_bus_if
  import data_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [StallWidth-1:0] stall,
  input  logic                  flush,
  input  logic                  cpu_ce_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic                  cpu_we_i,
  input  logic [SelWidth-1:0]   cpu_sel_i,
  input  logic [31:0]           cpu_data_i,
  output logic [31:0]           cpu_data_o,
  output logic                  stallreq,
  output logic                  bus_err_o,
  input  logic [31:0]           wb_data_i,
  input  logic                  wb_ack_i,
  output logic [31:0]           wb_addr_o,
  output logic [31:0]           wb_data_o,
  output logic                  wb_we_o,
  output logic [SelWidth-1:0]   wb_sel_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o
);

  // A zero-cycle timeout would give a zero-width counter; keep one bit instead.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  bus_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  reg_bus_t            r_rd_buf;
  logic                r_bus_err;
  logic [31:0]         r_wb_addr;
  logic [31:0]         r_wb_data;
  logic                r_wb_we;
  logic [SelWidth-1:0] r_wb_sel;
  logic                r_wb_stb;
  logic                r_wb_cyc;

  bus_state_e          w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  reg_bus_t            w_rd_buf_nxt;
  logic                w_bus_err_nxt;
  logic [31:0]         w_wb_addr_nxt;
  logic [31:0]         w_wb_data_nxt;
  logic                w_wb_we_nxt;
  logic [SelWidth-1:0] w_wb_sel_nxt;
  logic                w_wb_stb_nxt;
  logic                w_wb_cyc_nxt;
  logic                w_stall_any;
  logic                w_timeout_hit;
  logic                w_stallreq;
  logic [31:0]         w_cpu_data;

  assign w_stall_any   = |stall;
  assign w_timeout_hit = TIMEOUT_EN && (r_state == ST_BUSY) && (r_cnt == CNT_LAST);

  // State register and all registered bus-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rd_buf  <= ZeroWord;
      r_bus_err <= 1'b0;
      r_wb_addr <= ZeroWord;
      r_wb_data <= ZeroWord;
      r_wb_we   <= WriteDisable;
      r_wb_sel  <= 4'b0000;
      r_wb_stb  <= 1'b0;
      r_wb_cyc  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_buf  <= w_rd_buf_nxt;
      r_bus_err <= w_bus_err_nxt;
      r_wb_addr <= w_wb_addr_nxt;
      r_wb_data <= w_wb_data_nxt;
      r_wb_we   <= w_wb_we_nxt;
      r_wb_sel  <= w_wb_sel_nxt;
      r_wb_stb  <= w_wb_stb_nxt;
      r_wb_cyc  <= w_wb_cyc_nxt;
    end
  end

  // Next-state logic plus the combinational stall request and load data.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rd_buf_nxt  = r_rd_buf;
    w_bus_err_nxt = 1'b0;
    w_wb_addr_nxt = r_wb_addr;
    w_wb_data_nxt = r_wb_data;
    w_wb_we_nxt   = r_wb_we;
    w_wb_sel_nxt  = r_wb_sel;
    w_wb_stb_nxt  = r_wb_stb;
    w_wb_cyc_nxt  = r_wb_cyc;
    w_stallreq    = 1'b0;
    w_cpu_data    = ZeroWord;

    if (flush) begin
      // Flush wins over a same-cycle ack or timeout: abandon silently.
      w_state_nxt   = ST_IDLE;
      w_cnt_nxt     = '0;
      w_rd_buf_nxt  = ZeroWord;
      w_wb_addr_nxt = ZeroWord;
      w_wb_data_nxt = ZeroWord;
      w_wb_we_nxt   = WriteDisable;
      w_wb_sel_nxt  = 4'b0000;
      w_wb_stb_nxt  = 1'b0;
      w_wb_cyc_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_stallreq = cpu_ce_i;
          if (cpu_ce_i == ChipEnable) begin
            w_wb_addr_nxt = cpu_addr_i;
            w_wb_data_nxt = cpu_data_i;
            w_wb_we_nxt   = cpu_we_i;
            w_wb_sel_nxt  = cpu_sel_i;
            w_wb_stb_nxt  = 1'b1;
            w_wb_cyc_nxt  = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_BUSY;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (wb_ack_i || w_timeout_hit) begin
            // A timeout completes like an ack that returned zero.
            w_cpu_data    = wb_ack_i ? wb_data_i : ZeroWord;
            w_rd_buf_nxt  = wb_ack_i ? wb_data_i : ZeroWord;
            w_bus_err_nxt = ~wb_ack_i;
            w_cnt_nxt     = '0;
            w_wb_addr_nxt = ZeroWord;
            w_wb_data_nxt = ZeroWord;
            w_wb_we_nxt   = WriteDisable;
            w_wb_sel_nxt  = 4'b0000;
            w_wb_stb_nxt  = 1'b0;
            w_wb_cyc_nxt  = 1'b0;
            w_state_nxt   = w_stall_any ? ST_WAIT_FOR_STALL : ST_IDLE;
          end else begin
            w_stallreq = 1'b1;
            w_cnt_nxt  = TIMEOUT_EN ? (r_cnt + CNT_ONE) : r_cnt;
          end
        end
        ST_WAIT_FOR_STALL: begin
          w_cpu_data = r_rd_buf;
          if (!w_stall_any) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT_FOR_STALL;
          end
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = '0;
          w_wb_addr_nxt = ZeroWord;
          w_wb_data_nxt = ZeroWord;
          w_wb_we_nxt   = WriteDisable;
          w_wb_sel_nxt  = 4'b0000;
          w_wb_stb_nxt  = 1'b0;
          w_wb_cyc_nxt  = 1'b0;
        end
      endcase
    end

    if (rst) begin
      w_stallreq = 1'b0;
      w_cpu_data = ZeroWord;
    end else begin
      w_stallreq = w_stallreq;
    end
  end

  assign stallreq   = w_stallreq;
  assign cpu_data_o = w_cpu_data;
  assign bus_err_o  = r_bus_err;
  assign wb_addr_o  = r_wb_addr;
  assign wb_data_o  = r_wb_data;
  assign wb_we_o    = r_wb_we;
  assign wb_sel_o   = r_wb_sel;
  assign wb_stb_o   = r_wb_stb;
  assign wb_cyc_o   = r_wb_cyc;

endmodule

// File: tb/tb_data_bus_if.sv
// Scoreboard bench for data_bus_if: directed requests push expected bus cycles
// and load responses; a negedge monitor pops and compares them as they appear.
module tb_data_bus_if;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [3:0]  sel;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic        bus_err_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          err_cnt  = 0;
  logic        prev_cyc = 1'b0;
  req_t        req_q[$];
  logic [31:0] resp_q[$];

  data_bus_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq(stallreq), .bus_err_o(bus_err_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                       input logic [31:0] data);
    req_t r;
    cpu_ce_i   = 1'b1;
    cpu_addr_i = addr;
    cpu_we_i   = we;
    cpu_sel_i  = sel;
    cpu_data_i = data;
    r.addr = addr;
    r.data = data;
    r.we   = we;
    r.sel  = sel;
    req_q.push_back(r);
  endtask

  // Monitor: a new bus cycle pops a request; a consumed response pops load data.
  always @(negedge clk) begin
    req_t r;
    if (wb_cyc_o && !prev_cyc) begin
      if (req_q.size() == 0) begin
        chk("bus_cycle_unexpected", wb_addr_o, 32'hFFFF_FFFF);
      end else begin
        r = req_q.pop_front();
        chk("req_addr", wb_addr_o, r.addr);
        chk("req_data", wb_data_o, r.data);
        chk("req_we", {31'd0, wb_we_o}, {31'd0, r.we});
        chk("req_sel", {28'd0, wb_sel_o}, {28'd0, r.sel});
        chk("req_stb", {31'd0, wb_stb_o}, 32'd1);
      end
    end
    prev_cyc = wb_cyc_o;
    if (!rst && cpu_ce_i && !stallreq) begin
      if (resp_q.size() == 0) begin
        chk("resp_unexpected", cpu_data_o, 32'hFFFF_FFFF);
      end else begin
        chk("resp_data", cpu_data_o, resp_q.pop_front());
      end
    end
    if (bus_err_o) err_cnt++;
  end

  initial begin
    rst = 1'b1; stall = 6'd0; flush = 1'b0; cpu_ce_i = 1'b0; cpu_addr_i = 32'd0;
    cpu_we_i = 1'b0; cpu_sel_i = 4'd0; cpu_data_i = 32'd0; wb_data_i = 32'd0; wb_ack_i = 1'b0;
    repeat (2) tick();
    cpu_ce_i = 1'b1;
    @(negedge clk);
    chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
    chk("rst_cpu_data", cpu_data_o, 32'd0);
    chk("rst_cyc_stb_we_err", {28'd0, wb_cyc_o, wb_stb_o, wb_we_o, bus_err_o}, 32'd0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("rst_addr", wb_addr_o, 32'd0);
    chk("rst_wdata", wb_data_o, 32'd0);
    tick(); rst = 1'b0; cpu_ce_i = 1'b0;
    @(negedge clk);
    chk("idle_stallreq", {31'd0, stallreq}, 32'd0);

    // Load, ack in cycle 3
    tick(); issue(32'h0000_0080, 1'b0, 4'b1111, 32'd0);
    @(negedge clk); chk("load_c0_stallreq", {31'd0, stallreq}, 32'd1);
    chk("load_c0_cyc", {31'd0, wb_cyc_o}, 32'd0);
    tick(); @(negedge clk); chk("load_c1_stallreq", {31'd0, stallreq}, 32'd1);
    chk("load_c1_cyc", {31'd0, wb_cyc_o}, 32'd1);
    tick(); @(negedge clk); chk("load_c2_stallreq", {31'd0, stallreq}, 32'd1);
    tick(); wb_ack_i = 1'b1; wb_data_i = 32'hDEAD_BEEF; resp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk); chk("load_c3_stallreq", {31'd0, stallreq}, 32'd0);
    tick(); wb_ack_i = 1'b0; wb_data_i = 32'd0; cpu_ce_i = 1'b0;
    @(negedge clk); chk("load_c4_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);

    // Store byte, minimum 2-cycle access
    tick(); issue(32'h0000_0013, 1'b1, 4'b0001, 32'h5A5A_5A5A);
    @(negedge clk); chk("store_c0_stallreq", {31'd0, stallreq}, 32'd1);
    tick(); wb_ack_i = 1'b1; wb_data_i = 32'hCAFE_0000; resp_q.push_back(32'hCAFE_0000);
    @(negedge clk); chk("store_c1_stallreq", {31'd0, stallreq}, 32'd0);
    chk("store_c1_we", {31'd0, wb_we_o}, 32'd1);
    // Back-to-back request in the first IDLE cycle
    tick(); wb_ack_i = 1'b0; issue(32'h0000_0100, 1'b0, 4'b1111, 32'd0);
    @(negedge clk);
    chk("store_clr_ctl", {28'd0, wb_cyc_o, wb_stb_o, wb_we_o, 1'b0}, 32'd0);
    chk("store_clr_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("store_clr_addr", wb_addr_o, 32'd0);
    chk("store_clr_wdata", wb_data_o, 32'd0);
    chk("b2b_stallreq", {31'd0, stallreq}, 32'd1);

    // Stall hold: ack with stall set, then three more stalled cycles
    tick(); wb_ack_i = 1'b1; wb_data_i = 32'h0000_1234; stall = 6'b000011;
    resp_q.push_back(32'h0000_1234);
    @(negedge clk); chk("hold_ack_stallreq", {31'd0, stallreq}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); wb_ack_i = 1'b0; wb_data_i = 32'hFFFF_FFFF; resp_q.push_back(32'h0000_1234);
      @(negedge clk); chk("hold_stallreq", {31'd0, stallreq}, 32'd0);
      chk("hold_cyc", {31'd0, wb_cyc_o}, 32'd0);
    end
    tick(); stall = 6'd0; resp_q.push_back(32'h0000_1234);
    @(negedge clk); chk("hold_release_data", cpu_data_o, 32'h0000_1234);
    tick(); cpu_ce_i = 1'b0;
    @(negedge clk); chk("hold_idle_data", cpu_data_o, 32'd0);
    chk("hold_idle_cyc", {31'd0, wb_cyc_o}, 32'd0);

    // Flush in the second BUSY cycle together with an ack
    tick(); issue(32'h0000_0200, 1'b0, 4'b1111, 32'd0);
    tick(); @(negedge clk); chk("flush_busy1_stallreq", {31'd0, stallreq}, 32'd1);
    tick(); wb_ack_i = 1'b1; wb_data_i = 32'hAAAA_5555; flush = 1'b1; resp_q.push_back(32'd0);
    @(negedge clk); chk("flush_stallreq", {31'd0, stallreq}, 32'd0);
    tick(); wb_ack_i = 1'b0; flush = 1'b0; cpu_ce_i = 1'b0;
    @(negedge clk); chk("flush_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("flush_rd_buf", dut.r_rd_buf, 32'd0);
    chk("flush_no_err", {31'd0, bus_err_o}, 32'd0);
    tick(); @(negedge clk); chk("flush_no_err2", {31'd0, bus_err_o}, 32'd0);

    // Timeout after 4 BUSY cycles without ack
    tick(); issue(32'h0000_0300, 1'b1, 4'b1100, 32'h1122_3344); wb_data_i = 32'h7777_7777;
    @(negedge clk); chk("to_c0_stallreq", {31'd0, stallreq}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick(); @(negedge clk); chk("to_busy_stallreq", {31'd0, stallreq}, 32'd1);
      chk("to_busy_err", {31'd0, bus_err_o}, 32'd0);
    end
    tick(); resp_q.push_back(32'd0);
    @(negedge clk); chk("to_hit_stallreq", {31'd0, stallreq}, 32'd0);
    chk("to_hit_err", {31'd0, bus_err_o}, 32'd0);
    tick(); cpu_ce_i = 1'b0;
    @(negedge clk); chk("to_err_pulse", {31'd0, bus_err_o}, 32'd1);
    chk("to_cyc", {31'd0, wb_cyc_o}, 32'd0);
    tick(); @(negedge clk); chk("to_err_drop", {31'd0, bus_err_o}, 32'd0);

    // Reset mid-transfer
    tick(); issue(32'h0000_0400, 1'b0, 4'b1111, 32'd0); wb_data_i = 32'd0;
    tick(); rst = 1'b1;
    @(negedge clk); chk("rmid_cyc_held", {31'd0, wb_cyc_o}, 32'd1);
    chk("rmid_stallreq", {31'd0, stallreq}, 32'd0);
    tick(); rst = 1'b0; cpu_ce_i = 1'b0;
    @(negedge clk); chk("rmid_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rmid_addr", wb_addr_o, 32'd0);

    repeat (2) tick();
    @(negedge clk);
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("resp_q_drained", resp_q.size(), 32'd0);
    chk("bus_err_total", err_cnt, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
